aes_inv_cipher_iter: RTL and testbench

AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

---
 rtl/aes_inv_cipher_iter.sv | 173 +++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128/192/256.
// UNROLL selects one or two inverse rounds per clock; the expanded key is supplied whole.
module aes_inv_cipher_iter #(
  parameter int unsigned UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    cipher_in,
  input  logic [1919:0]   w_in,
  input  logic [3:0]      nr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    plain_out,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [3:0] STEP = 4'(UNROLL);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int unsigned k = 0; k < 7; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sub(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [127:0] pick_rk(input logic [1919:0] w, input logic [3:0] idx);
    logic [127:0] k;
    k = '0;
    for (int unsigned i = 0; i < 15; i++)
      if (idx == 4'(i)) k = w[128*i +: 128];
    return k;
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = inv_sub(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
    t = t ^ rk;
    m = t;
    if (!last) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end
    return m;
  endfunction

  state_e         st_q;
  logic [3:0]     cnt_q;
  logic [127:0]   blk_q;
  logic [127:0]   plain_q;
  logic [1919:0]  w_q;
  logic           out_valid_q;
  logic           err_q;

  logic [127:0]   round_d;
  logic           last_d;

  generate
    if (UNROLL == 2) begin : g_unroll2
      // Counter is always odd here, so the first stage is never the final round.
      logic [127:0] mid;
      always_comb begin
        mid     = inv_round(blk_q, pick_rk(w_q, cnt_q), 1'b0);
        last_d  = (cnt_q == 4'd1);
        round_d = inv_round(mid, pick_rk(w_q, cnt_q - 4'd1), last_d);
      end
    end else begin : g_unroll1
      always_comb begin
        last_d  = (cnt_q == 4'd0);
        round_d = inv_round(blk_q, pick_rk(w_q, cnt_q), last_d);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      w_q         <= '0;
      plain_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (st_q)
        IDLE: begin
          if (in_valid) begin
            if (nr == 4'd10 || nr == 4'd12 || nr == 4'd14) begin
              w_q   <= w_in;
              blk_q <= cipher_in ^ pick_rk(w_in, nr);
              cnt_q <= nr - 4'd1;
              st_q  <= ROUND;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ROUND: begin
          blk_q <= round_d;
          cnt_q <= cnt_q - STEP;
          if (last_d) begin
            cnt_q       <= '0;
            st_q        <= DONE;
            out_valid_q <= 1'b1;
            plain_q     <= round_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            plain_q     <= '0;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = out_valid_q;
  assign plain_out = plain_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: UNROLL=1 and UNROLL=2 instances share stimulus and are
// checked every cycle against a FIPS-197 byte-array reference with per-block latency rules.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready1, out_ready2;
  logic [127:0]   cipher_in;
  logic [1919:0]  w_in;
  logic [3:0]     nr;
  logic           in_ready1, in_ready2, out_valid1, out_valid2, err1, err2;
  logic [127:0]   plain1, plain2;

  aes_inv_cipher_iter #(.UNROLL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .cipher_in(cipher_in),
    .w_in(w_in), .nr(nr), .out_valid(out_valid1), .out_ready(out_ready1),
    .plain_out(plain1), .err(err1));

  aes_inv_cipher_iter #(.UNROLL(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .cipher_in(cipher_in),
    .w_in(w_in), .nr(nr), .out_valid(out_valid2), .out_ready(out_ready2),
    .plain_out(plain2), .err(err2));

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox [256];
  logic [7:0] isbox[256];
  logic [7:0] IM [16] = '{8'h0e, 8'h0b, 8'h0d, 8'h09,
                          8'h09, 8'h0e, 8'h0b, 8'h0d,
                          8'h0d, 8'h09, 8'h0e, 8'h0b,
                          8'h0b, 8'h0d, 8'h09, 8'h0e};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Key expansion for the FIPS test key 00 01 02 ... (nk*4 bytes).
  function automatic logic [1919:0] expand(input int nk);
    logic [31:0]   w[60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] res = '0;
    int            rounds = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(rounds+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= rounds; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [1919:0] w,
                                               input int n);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [127:0] rk;
    logic [127:0] o;
    rk = w[128*n +: 128];
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rk[127-8*k -: 8];
    for (int rd = n - 1; rd >= 0; rd--) begin
      rk = w[128*rd +: 128];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      for (int k = 0; k < 16; k++) t[k] = isbox[t[k]] ^ rk[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          s[r+4*c] = 8'h00;
          if (rd > 0) begin
            for (int j = 0; j < 4; j++) s[r+4*c] ^= mul(IM[4*r+j], t[j+4*c]);
          end else begin
            s[r+4*c] = t[r+4*c];
          end
        end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Per-DUT model: mode 0 idle, 1 computing, 2 holding result.
  int           cyc = 0;
  logic         started = 1'b0;
  int           m_mode[2], m_left[2], rise_cyc[2];
  logic         m_valid[2], m_err[2], prev_v[2];
  logic [127:0] m_pt[2], m_pend[2], cap_pt[2];
  logic [127:0] res_q[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_left[d] = 0; m_valid[d] = 1'b0; m_err[d] = 1'b0;
      m_pt[d] = '0; m_pend[d] = '0; prev_v[d] = 1'b0; rise_cyc[d] = -1; cap_pt[d] = '0;
    end
  end

  always @(posedge clk) begin
    logic         ir, ov, er, ordy;
    logic [127:0] po;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      ordy = (d == 0) ? out_ready1 : out_ready2;
      if (rst) begin
        m_mode[d] = 0; m_valid[d] = 1'b0; m_pt[d] = '0; m_err[d] = 1'b0;
      end else begin
        m_err[d] = 1'b0;
        case (m_mode[d])
          0: if (in_valid) begin
               if (nr == 4'd10 || nr == 4'd12 || nr == 4'd14) begin
                 m_pend[d] = ref_decrypt(cipher_in, w_in, int'(nr));
                 m_left[d] = int'(nr) / (d + 1);
                 m_mode[d] = 1;
               end else begin
                 m_err[d] = 1'b1;
               end
             end
          1: begin
               m_left[d]--;
               if (m_left[d] == 0) begin m_mode[d] = 2; m_valid[d] = 1'b1; m_pt[d] = m_pend[d]; end
             end
          default: if (ordy) begin m_mode[d] = 0; m_valid[d] = 1'b0; m_pt[d] = '0; end
        endcase
      end
    end
    if (rst) started = 1'b1;
    #1;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        ir = (d == 0) ? in_ready1  : in_ready2;
        ov = (d == 0) ? out_valid1 : out_valid2;
        er = (d == 0) ? err1       : err2;
        po = (d == 0) ? plain1     : plain2;
        chk($sformatf("u%0d.in_ready@%0d", d+1, cyc), {127'd0, ir}, {127'd0, m_mode[d] == 0});
        chk($sformatf("u%0d.out_valid@%0d", d+1, cyc), {127'd0, ov}, {127'd0, m_valid[d]});
        chk($sformatf("u%0d.err@%0d", d+1, cyc), {127'd0, er}, {127'd0, m_err[d]});
        chk($sformatf("u%0d.plain_out@%0d", d+1, cyc), po, m_pt[d]);
        if (ov && !prev_v[d]) begin
          rise_cyc[d] = cyc;
          cap_pt[d]   = po;
          if (d == 0) res_q.push_back(po);
        end
        prev_v[d] = ov;
      end
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(in_ready1 && in_ready2) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail_now(name);
  endtask

  task automatic run_block(input string name, input logic [127:0] ct, input logic [1919:0] w,
                           input logic [3:0] n, input int lat1, input int lat2);
    int acc;
    rise_cyc[0] = -1; rise_cyc[1] = -1;
    cipher_in = ct; w_in = w; nr = n; in_valid = 1'b1;
    @(posedge clk); #2;
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; cipher_in = '0; w_in = '0; nr = 4'd0;
    wait_idle({name, ".done"});
    chk({name, ".lat_u1"}, 128'(rise_cyc[0] - acc), 128'(lat1));
    chk({name, ".lat_u2"}, 128'(rise_cyc[1] - acc), 128'(lat2));
    chk({name, ".pt_u1"}, cap_pt[0], PT);
    chk({name, ".pt_u2"}, cap_pt[1], PT);
  endtask

  logic [1919:0] w128, w192, w256;

  initial begin
    logic [7:0] inv, s;
    int         t, acc[3];
    logic [127:0] cts[3];
    logic [1919:0] ws[3];
    logic [3:0]   nrs[3];

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
    w128 = expand(4);
    w192 = expand(6);
    w256 = expand(8);

    chk("model.sbox53", {120'd0, sbox[8'h53]}, 128'hed);
    chk("model.isbox00", {120'd0, isbox[8'h00]}, 128'h52);
    chk("model.rk10_aes128", w128[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model.dec128", ref_decrypt(CT128, w128, 10), PT);
    chk("model.dec192", ref_decrypt(CT192, w192, 12), PT);
    chk("model.dec256", ref_decrypt(CT256, w256, 14), PT);

    rst = 1'b1; in_valid = 1'b0; cipher_in = '0; w_in = '0; nr = 4'd0;
    out_ready1 = 1'b1; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.in_ready_u1", {127'd0, in_ready1}, 128'd1);
    chk("reset.in_ready_u2", {127'd0, in_ready2}, 128'd1);
    chk("reset.out_valid_u1", {127'd0, out_valid1}, 128'd0);
    chk("reset.plain_u2", plain2, 128'd0);
    chk("reset.err_u1", {127'd0, err1}, 128'd0);

    run_block("aes128", CT128, w128, 4'd10, 10, 5);
    run_block("aes192", CT192, w192, 4'd12, 12, 6);
    run_block("aes256", CT256, w256, 4'd14, 14, 7);

    // Backpressure: hold u1 for five valid cycles, release in the sixth.
    out_ready1 = 1'b0; out_ready2 = 1'b0;
    cipher_in = CT128; w_in = w128; nr = 4'd10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("bp.wait_valid");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.valid_c%0d", i), {127'd0, out_valid1}, 128'd1);
      chk($sformatf("bp.plain_c%0d", i), plain1, PT);
      chk($sformatf("bp.in_ready_c%0d", i), {127'd0, in_ready1}, 128'd0);
      @(negedge clk);
    end
    out_ready1 = 1'b1;
    @(posedge clk); #2;
    chk("bp.idle_in_ready", {127'd0, in_ready1}, 128'd1);
    chk("bp.idle_valid", {127'd0, out_valid1}, 128'd0);
    chk("bp.idle_plain", plain1, 128'd0);
    @(negedge clk);
    out_ready2 = 1'b1;
    wait_idle("bp.release_u2");

    // Illegal round count.
    cipher_in = CT128; w_in = w128; nr = 4'd11; in_valid = 1'b1;
    @(posedge clk); #2;
    chk("illegal.err_u1", {127'd0, err1}, 128'd1);
    chk("illegal.err_u2", {127'd0, err2}, 128'd1);
    chk("illegal.in_ready", {127'd0, in_ready1}, 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("illegal.err_cleared", {127'd0, err1}, 128'd0);
    chk("illegal.still_ready", {127'd0, in_ready2}, 128'd1);
    @(negedge clk);

    // Reset sampled at the end of the fifth ROUND cycle aborts the block.
    rise_cyc[0] = -1; rise_cyc[1] = -1;
    cipher_in = CT256; w_in = w256; nr = 4'd14; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.no_valid_u1", 128'(rise_cyc[0]), 128'(-1));
    chk("abort.no_valid_u2", 128'(rise_cyc[1]), 128'(-1));
    run_block("after_rst", CT128, w128, 4'd10, 10, 5);

    // Back-to-back mixed key sizes with in_valid held.
    cts = '{CT256, CT128, CT192};
    ws  = '{w256, w128, w192};
    nrs = '{4'd14, 4'd10, 4'd12};
    res_q.delete();
    for (int b = 0; b < 3; b++) begin
      cipher_in = cts[b]; w_in = ws[b]; nr = nrs[b]; in_valid = 1'b1;
      t = 0;
      while (!in_ready1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail_now($sformatf("b2b.accept%0d", b));
      @(posedge clk); #2;
      acc[b] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_idle("b2b.drain");
    chk("b2b.spacing_14", 128'(acc[1] - acc[0]), 128'd16);
    chk("b2b.spacing_10", 128'(acc[2] - acc[1]), 128'd12);
    chk("b2b.count", 128'(res_q.size()), 128'd3);
    for (int b = 0; b < res_q.size(); b++) chk($sformatf("b2b.pt%0d", b), res_q[b], PT);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
